// File: rtl/nota_pkg.sv
// rtl/nota_pkg.sv - shared types, sizes and column-encode helper for the keypad encoder
package nota_pkg;

    localparam int KEY_W = 4;
    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int ROW_W = 2;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        ACCEPT,
        RELEASE
    } nota_state_t;

    // Index of the lowest active-low column; lowest index wins when several are low
    function automatic logic [ROW_W-1:0] low_col(input logic [COLS-1:0] pat);
        logic [ROW_W-1:0] idx;
        idx = '0;
        for (int i = COLS - 1; i >= 0; i--) begin
            if (!pat[i]) begin
                idx = ROW_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/col_sync.sv
// rtl/col_sync.sv - two-flop synchroniser for the asynchronous keypad column lines
module col_sync
    import nota_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic [COLS-1:0] cols_async,
    output logic [COLS-1:0] cols_sync
);

    logic [COLS-1:0] meta;

    // Resets to all-ones so an idle (released) keypad is seen right after reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta      <= '1;
            cols_sync <= '1;
        end else begin
            meta      <= cols_async;
            cols_sync <= meta;
        end
    end

endmodule

// File: rtl/nota_keypad_encoder.sv
// rtl/nota_keypad_encoder.sv - 4x4 keypad scanner, debouncer and key encoder
module nota_keypad_encoder
    import nota_pkg::*;
#(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [COLS-1:0] cols,
    output logic [ROWS-1:0] rows,
    output logic            a,
    output logic            b,
    output logic            c,
    output logic            d,
    output logic            ready,
    output logic            strobe
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [COLS-1:0]  cs;
    logic             pressed;

    nota_state_t      state, state_next;
    logic [ROW_W-1:0] r, r_next;
    logic [DIV_W-1:0] div, div_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [COLS-1:0]  pat, pat_next;
    logic             accept;
    logic [KEY_W-1:0] code;

    col_sync u_col_sync (
        .clock      (clock),
        .reset      (reset),
        .cols_async (cols),
        .cols_sync  (cs)
    );

    assign pressed = ~&cs;
    assign rows    = ~(4'b0001 << r);
    assign {a, b, c, d} = code;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= SCAN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic plus next values for row, scan divider, debounce counter and pattern
    always_comb begin
        state_next = state;
        r_next     = r;
        div_next   = div;
        cnt_next   = cnt;
        pat_next   = pat;
        accept     = 1'b0;
        case (state)
            SCAN: begin
                if (pressed) begin
                    pat_next   = cs;
                    cnt_next   = '0;
                    state_next = DEBOUNCE;
                end else if (div == DIV_LAST) begin
                    div_next = '0;
                    r_next   = r + 2'd1;
                end else begin
                    div_next = div + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (cs != pat) begin
                    div_next   = '0;
                    state_next = SCAN;
                end else if (cnt == CNT_LAST) begin
                    state_next = ACCEPT;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            ACCEPT: begin
                accept     = 1'b1;
                cnt_next   = '0;
                state_next = RELEASE;
            end
            RELEASE: begin
                if (pressed) begin
                    cnt_next = '0;
                end else if (cnt == CNT_LAST) begin
                    cnt_next   = '0;
                    div_next   = '0;
                    state_next = SCAN;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = SCAN;
            end
        endcase
    end

    // Row index, scan divider, debounce counter and captured column pattern
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r   <= '0;
            div <= '0;
            cnt <= '0;
            pat <= '1;
        end else begin
            r   <= r_next;
            div <= div_next;
            cnt <= cnt_next;
            pat <= pat_next;
        end
    end

    // Output registers: code and ready load only on accept; strobe follows accept by one cycle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            code   <= '0;
            ready  <= 1'b0;
            strobe <= 1'b0;
        end else begin
            strobe <= accept;
            if (accept) begin
                code  <= {r, low_col(pat)};
                ready <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nota_keypad_encoder.sv
// tb/tb_nota_keypad_encoder.sv - directed self-checking bench for nota_keypad_encoder
module tb_nota_keypad_encoder;

    logic       clock;
    logic       reset;
    logic [3:0] cols;
    logic [3:0] rows;
    logic       a, b, c, d;
    logic       ready;
    logic       strobe;

    logic [3:0] kp [4];

    int compared   = 0;
    int mismatched = 0;

    int         n1, n2, n3, first;
    logic [3:0] code1, code2;

    nota_keypad_encoder #(
        .SCAN_DIV        (4),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .cols   (cols),
        .rows   (rows),
        .a      (a),
        .b      (b),
        .c      (c),
        .d      (d),
        .ready  (ready),
        .strobe (strobe)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Keypad matrix: a column reads low only while the row holding that key is driven low
    always_comb begin
        cols = 4'hF;
        for (int i = 0; i < 4; i++) begin
            if (!rows[i]) begin
                cols = cols & kp[i];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run(input int n, output int nstrobe, output logic [3:0] scode, output int first_k);
        nstrobe = 0;
        scode   = 4'h0;
        first_k = -1;
        for (int k = 1; k <= n; k++) begin
            @(negedge clock);
            if (strobe) begin
                nstrobe++;
                if (first_k < 0) begin
                    first_k = k;
                    scode   = {a, b, c, d};
                end
            end
        end
    endtask

    task automatic wait_row(input int idx);
        logic [3:0] target;
        logic       found;
        target = ~(4'b0001 << idx);
        found  = 1'b0;
        for (int k = 0; k < 40 && rows == target; k++) @(negedge clock);
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (rows == target) begin
                found = 1'b1;
                break;
            end
        end
        check("wait_row", found, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},  ready, 1'b0);
        check({tag, "_code"},   {a, b, c, d}, 4'h0);
        check({tag, "_rows"},   rows, 4'b1110);
        check({tag, "_strobe"}, strobe, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) kp[i] = 4'hF;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("por");
        repeat (2) @(negedge clock);
        reset = 1'b1;

        // Basic press: key at row 2 / col 1 -> 1001, strobe 12 cycles after cols falls
        wait_row(2);
        kp[2] = 4'b1101;
        run(40, n1, code1, first);
        check("basic_latency", first, 12);
        check("basic_nstrobe", n1, 1);
        check("basic_code", code1, 4'b1001);
        check("basic_ready", ready, 1'b1);
        kp[2] = 4'hF;
        run(20, n1, code1, first);
        check("basic_release_nstrobe", n1, 0);

        // Bounce on row 1 col 0: 5 low, 2 high, 20 low -> single accept of 0100
        wait_row(1);
        kp[1] = 4'b1110;
        run(5, n1, code1, first);
        kp[1] = 4'hF;
        run(2, n2, code1, first);
        check("bounce_abort", n1 + n2, 0);
        check("bounce_abort_code", {a, b, c, d}, 4'b1001);
        kp[1] = 4'b1110;
        run(20, n3, code2, first);
        check("bounce_nstrobe", n3, 1);
        check("bounce_code", code2, 4'b0100);
        kp[1] = 4'hF;
        run(20, n1, code1, first);
        check("bounce_hold_nstrobe", n1, 0);
        check("bounce_hold_code", {a, b, c, d}, 4'b0100);
        check("bounce_hold_ready", ready, 1'b1);

        // Multi-column on row 3: cols 0110 resolves to col 0 -> 1100
        kp[3] = 4'b0110;
        run(50, n1, code1, first);
        check("multi_nstrobe", n1, 1);
        check("multi_code", code1, 4'b1100);
        kp[3] = 4'hF;
        run(20, n1, code1, first);

        // Re-accept: key 5, short release, key 7 held is ignored until a full release
        kp[1] = 4'b1101;
        run(50, n1, code1, first);
        check("key5_nstrobe", n1, 1);
        check("key5_code", code1, 4'b0101);
        kp[1] = 4'hF;
        run(5, n1, code1, first);
        kp[1] = 4'b0111;
        run(30, n2, code1, first);
        check("key7_blocked", n1 + n2, 0);
        check("key7_blocked_code", {a, b, c, d}, 4'b0101);
        kp[1] = 4'hF;
        run(12, n1, code1, first);
        check("key7_release", n1, 0);
        kp[1] = 4'b0111;
        run(50, n1, code1, first);
        check("key7_nstrobe", n1, 1);
        check("key7_code", code1, 4'b0111);
        kp[1] = 4'hF;
        run(20, n1, code1, first);

        // Reset in DEBOUNCE for key A
        wait_row(2);
        kp[2] = 4'b1011;
        run(6, n1, code1, first);
        reset = 1'b0;
        #1;
        check_reset_outputs("rst_deb");
        kp[2] = 4'hF;
        @(negedge clock);
        reset = 1'b1;
        run(4, n1, code1, first);
        check("rst_deb_rows_resume", rows, 4'b1101);
        run(20, n2, code1, first);
        check("rst_deb_nstrobe", n1 + n2, 0);
        check("rst_deb_ready", ready, 1'b0);

        // Reset in RELEASE after key A accepted
        kp[2] = 4'b1011;
        run(50, n1, code1, first);
        check("keyA_nstrobe", n1, 1);
        check("keyA_code", code1, 4'b1010);
        check("keyA_ready", ready, 1'b1);
        kp[2] = 4'hF;
        run(3, n1, code1, first);
        reset = 1'b0;
        #1;
        check_reset_outputs("rst_rel");
        @(negedge clock);
        reset = 1'b1;
        run(4, n1, code1, first);
        check("rst_rel_rows_resume", rows, 4'b1101);
        run(30, n2, code1, first);
        check("rst_rel_nstrobe", n1 + n2, 0);
        check("rst_rel_ready", ready, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
